// File: rtl/half_adder_bist_pkg.sv
// Shared types and constants for the half-adder built-in self-test sequencer.
// The saturating counter helper is shared so every user clamps the same way.
package half_adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int ERR_W   = 8;
    localparam int NUM_VEC = 4;
    localparam int VEC_W   = 2;

    localparam logic [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] value);
        logic [ERR_W-1:0] result;
        if (value == ERR_MAX) begin
            result = value;
        end else begin
            result = value + ERR_ONE;
        end
        return result;
    endfunction

endpackage

// File: rtl/half_adder_bist_if.sv
// Bundle of the run-control, result and DUT-facing signals of the BIST block.
// The slave side is the sequencer; the master side is its environment.
interface half_adder_bist_if;
    import half_adder_bist_pkg::*;

    logic             start;
    logic             dut_a;
    logic             dut_b;
    logic             dut_s;
    logic             dut_c;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic             fail_valid;
    logic [VEC_W-1:0] fail_vec;

    modport slave (
        input  start,
        input  dut_s,
        input  dut_c,
        output dut_a,
        output dut_b,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_valid,
        output fail_vec
    );

    modport master (
        output start,
        output dut_s,
        output dut_c,
        input  dut_a,
        input  dut_b,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_valid,
        input  fail_vec
    );

endinterface

// File: rtl/half_adder_bist_half_ref.sv
// Golden half adder providing the expected sum and carry for the vector under test.
module half_ref (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/half_adder_bist.sv
// Exhaustive self-test sequencer for a half-adder primitive: walks the four
// input vectors REPEAT times, compares against half_ref and reports the result.
module half_adder_bist
    import half_adder_bist_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int REPEAT = 1
) (
    input logic              clk,
    input logic              rst,
    half_adder_bist_if.slave bus
);

    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam int IDX_W = $clog2(REPEAT + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] REPEAT_LAST = IDX_W'(REPEAT - 1);
    localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(NUM_VEC - 1);

    state_e           state_r;
    state_e           state_s;
    logic [VEC_W-1:0] vec_r;
    logic [VEC_W-1:0] vec_s;
    logic [IDX_W-1:0] pass_idx_r;
    logic [IDX_W-1:0] pass_idx_s;
    logic [CNT_W-1:0] settle_cnt_r;
    logic [CNT_W-1:0] settle_cnt_s;
    logic [ERR_W-1:0] err_count_r;
    logic [ERR_W-1:0] err_count_s;
    logic             fail_valid_r;
    logic             fail_valid_s;
    logic [VEC_W-1:0] fail_vec_r;
    logic [VEC_W-1:0] fail_vec_s;
    logic             pass_r;
    logic             pass_s;
    logic             busy_r;
    logic             done_r;
    logic             dut_a_r;
    logic             dut_b_r;
    logic             run_s;
    logic             ref_s_s;
    logic             ref_c_s;
    logic             mismatch_s;

    half_ref u_half_ref (
        .a (vec_r[1]),
        .b (vec_r[0]),
        .s (ref_s_s),
        .c (ref_c_s)
    );

    assign mismatch_s = ({bus.dut_c, bus.dut_s} != {ref_c_s, ref_s_s});

    // Next-state and result-update logic for the run sequencer.
    always_comb begin
        state_s      = state_r;
        vec_s        = vec_r;
        pass_idx_s   = pass_idx_r;
        settle_cnt_s = settle_cnt_r;
        err_count_s  = err_count_r;
        fail_valid_s = fail_valid_r;
        fail_vec_s   = fail_vec_r;
        pass_s       = pass_r;

        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    err_count_s  = ERR_ZERO;
                    fail_valid_s = 1'b0;
                    fail_vec_s   = {VEC_W{1'b0}};
                    pass_s       = 1'b0;
                    vec_s        = {VEC_W{1'b0}};
                    pass_idx_s   = {IDX_W{1'b0}};
                    settle_cnt_s = {CNT_W{1'b0}};
                    state_s      = DRIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE: begin
                settle_cnt_s = settle_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (settle_cnt_r == SETTLE_LAST) begin
                    state_s = SAMPLE;
                end else begin
                    state_s = DRIVE;
                end
            end
            SAMPLE: begin
                // Only the first failing vector is kept; later ones just count.
                if (mismatch_s) begin
                    err_count_s = sat_inc(err_count_r);
                    if (!fail_valid_r) begin
                        fail_valid_s = 1'b1;
                        fail_vec_s   = vec_r;
                    end else begin
                        fail_vec_s = fail_vec_r;
                    end
                end else begin
                    err_count_s = err_count_r;
                end

                settle_cnt_s = {CNT_W{1'b0}};
                if (vec_r == VEC_LAST) begin
                    if (pass_idx_r == REPEAT_LAST) begin
                        state_s = DONE;
                    end else begin
                        pass_idx_s = pass_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                        vec_s      = {VEC_W{1'b0}};
                        state_s    = DRIVE;
                    end
                end else begin
                    vec_s   = vec_r + {{(VEC_W-1){1'b0}}, 1'b1};
                    state_s = DRIVE;
                end
            end
            DONE: begin
                pass_s  = (err_count_r == ERR_ZERO);
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        run_s = (state_s == DRIVE) || (state_s == SAMPLE);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Sequencing counters and captured results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_r        <= {VEC_W{1'b0}};
            pass_idx_r   <= {IDX_W{1'b0}};
            settle_cnt_r <= {CNT_W{1'b0}};
            err_count_r  <= ERR_ZERO;
            fail_valid_r <= 1'b0;
            fail_vec_r   <= {VEC_W{1'b0}};
            pass_r       <= 1'b0;
        end else begin
            vec_r        <= vec_s;
            pass_idx_r   <= pass_idx_s;
            settle_cnt_r <= settle_cnt_s;
            err_count_r  <= err_count_s;
            fail_valid_r <= fail_valid_s;
            fail_vec_r   <= fail_vec_s;
            pass_r       <= pass_s;
        end
    end

    // Status and DUT-drive outputs decoded from the upcoming state so they
    // line up with that state while still coming straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dut_a_r <= 1'b0;
            dut_b_r <= 1'b0;
        end else begin
            busy_r  <= run_s;
            done_r  <= (state_s == DONE);
            dut_a_r <= run_s ? vec_s[1] : 1'b0;
            dut_b_r <= run_s ? vec_s[0] : 1'b0;
        end
    end

    assign bus.dut_a      = dut_a_r;
    assign bus.dut_b      = dut_b_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.pass       = pass_r;
    assign bus.err_count  = err_count_r;
    assign bus.fail_valid = fail_valid_r;
    assign bus.fail_vec   = fail_vec_r;

endmodule

// File: doc/half_adder_bist.md
# half_adder_bist

Built-in self-test sequencer for half-adder-class units. It drives the DUT inputs `a`/`b` through the four exhaustive vectors and samples the DUT's `s`/`c` outputs. Each response is compared against a golden model, and the block reports pass/fail, an error count and the first failing vector. It sits beside each adder primitive in the accelerator datapath so those primitives can be checked on-chip instead of only in simulation.

## Interface
Parameters:
- `SETTLE`, default 2: cycles each vector is held before sampling. Legal range ≥1.
- `REPEAT`, default 1: number of full 4-vector passes per run. Legal range ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request, sampled in IDLE only.
- `dut_a`  out  1  DUT input a.
- `dut_b`  out  1  DUT input b.
- `dut_s`  in  1  DUT sum output.
- `dut_c`  in  1  DUT carry output.
- `busy`  out  1  high while a run is in progress (DRIVE/SAMPLE).
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  high when the last run had zero errors. Holds until the next start.
- `err_count`  out  8  mismatch count for the last run, saturating at 255.
- `fail_valid`  out  1  at least one mismatch was captured in the last run.
- `fail_vec`  out  2  first failing vector as {a,b}.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- **IDLE**
  - `dut_a`=`dut_b`=0, `busy`=0.
  - On `start`=1: clear `err_count`, `fail_valid`, `fail_vec` and `pass`; set vec=0, pass_idx=0, settle_cnt=0; go to DRIVE.
- **DRIVE**
  - {`dut_a`,`dut_b`} = vec.
  - settle_cnt increments each cycle.
  - When settle_cnt == SETTLE-1, go to SAMPLE.
- **SAMPLE**
  - Vector is still driven.
  - Compare {`dut_c`,`dut_s`} against golden {a&b, a^b}.
  - On mismatch:
    - `err_count` += 1, saturating at 255.
    - If `fail_valid`=0, set `fail_valid`=1 and capture `fail_vec`=vec.
  - If vec==3 and pass_idx==REPEAT-1: go to DONE.
  - Else if vec==3: pass_idx += 1, vec=0, settle_cnt=0, go to DRIVE.
  - Else: vec += 1, settle_cnt=0, go to DRIVE.
- **DONE**
  - `done`=1 for this one cycle.
  - `pass` = (`err_count`==0), registered.
  - DUT inputs return to 0.
  - Next state is IDLE unconditionally.
- `start` is ignored in DRIVE, SAMPLE and DONE; there is no queuing.
- Result outputs hold their values from the end of a run until the next accepted `start`.

## Timing
- Reset value (`rst`=1, asynchronous): state=IDLE and every output 0, including `pass`, `err_count`, `fail_valid` and `fail_vec`.
- Reset asserted mid-run aborts the run immediately and leaves no partial result.
- Each vector occupies SETTLE+1 cycles: SETTLE in DRIVE plus 1 in SAMPLE.
- Run length: with `start` accepted on edge 0, DRIVE begins in cycle 1.
  - `done` is high in cycle 1 + 4·REPEAT·(SETTLE+1).
  - Defaults: `done` is high in cycle 13.
- DUT outputs are sampled on the rising edge that ends the SAMPLE cycle. The DUT must therefore settle within SETTLE+1 cycles of an input change.
- `busy` is high in every DRIVE and SAMPLE cycle and low in IDLE and DONE.
- Back-to-back runs: `start` may be re-asserted in the cycle after DONE, when the block is back in IDLE.

## Structure
- Shared package `half_adder_bist_pkg`:
  - state enum (IDLE/DRIVE/SAMPLE/DONE);
  - `ERR_W`=8;
  - `NUM_VEC`=4.
- One sub-module, `half_ref`: a combinational golden half adder (s=a^b, c=a&b) used for the expected values.
- Estimated size: about 150 lines of RTL.

## Test plan
- **Correct DUT**
  - Stimulus: loop `dut_a`/`dut_b` through a correct half adder, defaults, pulse `start`.
  - Required: `done` in cycle 13, `pass`=1, `err_count`=0, `fail_valid`=0.
- **Carry stuck at 0**
  - Stimulus: DUT carry forced to 0.
  - Required: `err_count`=1, `fail_valid`=1, `fail_vec`=2'b11, `pass`=0.
- **s and c swapped**
  - Stimulus: DUT with its `s` and `c` outputs exchanged.
  - Required: `err_count`=3, `fail_vec`=2'b01 (first failing vector), `pass`=0.
- **Saturation**
  - Stimulus: REPEAT=100, DUT sum inverted (400 mismatches).
  - Required: `err_count`=255, `done` in cycle 1+400·3=1201.
- **Reset mid-run**
  - Stimulus: assert `rst` in cycle 5.
  - Required: all outputs 0 in the same cycle, `busy`=0.
  - Required: a fresh `start` after reset completes normally with `pass`=1.
- **Start while busy**
  - Stimulus: re-assert `start` in cycles 3 and 8 of a run.
  - Required: no restart, `done` still in cycle 13, exactly one `done` pulse.
